// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Interlock unit that sits beside Decode of the in-order pipeline. Every
//   in-flight register write is tracked as a {valid, rd} tag that travels
//   E -> M -> ... -> WB alongside the real instruction. Decode is stalled on a
//   read-after-write hazard against any live tag. Wrong-path stages are flushed
//   on a taken jump. All tracking freezes while mem_stall is high.
//
//   Optional feature macro: HAZARD_FORWARD_EN
//     defined   : only a match in E stalls; matches in later stages are
//                 reported on fwd_sel1/fwd_sel2 as (stage index + 1).
//     undefined : any match stalls; fwd_sel1/fwd_sel2 are tied to 0.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   id_valid, id_rd_en         Decode holds an instruction; bit0 rs1 read, bit1 rs2 read
//   id_rs1, id_rs2             source registers
//   id_we, id_rd               Decode instruction writes id_rd
//   jump                       taken jump resolved in Execute this cycle
//   mem_stall                  external stall, freezes the pipeline
//   stall_F/D/E/M/WB           hold the stage registers
//   flush_D, flush_E           clear the stage register at the next edge
//   busy                       per-register pending-write mask
//   fwd_sel1, fwd_sel2         forwarding source select (0 = register file)
//   stall_cnt                  saturating count of hazard-stall cycles
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_rd_en,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_we,
  input  logic [AW-1:0]    id_rd,
  input  logic             jump,
  input  logic             mem_stall,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_WB,
  output logic             flush_D,
  output logic             flush_E,
  output logic [NREGS-1:0] busy,
  output logic [2:0]       fwd_sel1,
  output logic [2:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] match1, match2;
  logic             hazard;
  logic [NREGS-1:0] busy_raw;
  logic [2:0]       fwd1_raw, fwd2_raw;

  // Decode-stage comparison against every live tag
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match1[k] = valid_q[k] && (rd_q[k] == id_rs1) && (id_rs1 != '0) && id_rd_en[0];
      match2[k] = valid_q[k] && (rd_q[k] == id_rs2) && (id_rs2 != '0) && id_rd_en[1];
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Only a producer still in E cannot be forwarded from.
  assign hazard = id_valid && (match1[0] || match2[0]);

  // Descending scan so the youngest (lowest index) matching stage wins.
  always_comb begin
    fwd1_raw = 3'd0;
    fwd2_raw = 3'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match1[k]) fwd1_raw = 3'(k + 1);
      if (match2[k]) fwd2_raw = 3'(k + 1);
    end
  end
`else
  assign hazard   = id_valid && ((|match1) || (|match2));
  assign fwd1_raw = 3'd0;
  assign fwd2_raw = 3'd0;
`endif

  // Pending-write mask is the OR of all live tags
  always_comb begin
    busy_raw = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k]) busy_raw[rd_q[k]] = 1'b1;
    end
  end

  // Next tag state: shift one stage per unfrozen edge, load E from Decode
  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      if (jump || hazard || !id_valid) begin
        valid_d[0] = 1'b0;
        rd_d[0]    = '0;
      end else begin
        valid_d[0] = id_we && (id_rd != '0);
        rd_d[0]    = id_rd;
      end
      // A jump wins over the hazard, so that cycle is a flush, not a stall.
      if (hazard && !jump && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      rd_q        <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are held low for the whole reset cycle
  assign stall_F   = !reset && ((hazard && !jump) || mem_stall);
  assign stall_D   = stall_F;
  assign stall_E   = !reset && mem_stall;
  assign stall_M   = stall_E;
  assign stall_WB  = stall_E;
  assign flush_D   = !reset && jump && !mem_stall;
  assign flush_E   = !reset && (jump || hazard) && !mem_stall;
  assign busy      = reset ? '0 : busy_raw;
  assign fwd_sel1  = reset ? 3'd0 : fwd1_raw;
  assign fwd_sel2  = reset ? 3'd0 : fwd2_raw;
  assign stall_cnt = reset ? '0 : stall_cnt_q;

endmodule
